mem_stage_ctrl: RTL and testbench

- Memory stage sitting directly downstream of the Execute/Memory pipeline buffer.
- Consumes the buffered ALU result, store data, destination register, control bits, PC and interrupt flag.
- Performs data-memory load/store and single-word PUSH/POP against an internal stack pointer.
- Runs two-cycle sequences to push the PC on interrupt and pop it on RET/RTI, stalling upstream meanwhile. Feeds registered results to the Memory/Writeback buffer.

---
 rtl/mem_stage_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory pipeline stage between the Execute/Memory and Memory/Writeback
// buffers. Performs data-memory load/store, single-word PUSH/POP against an
// internal downward-growing stack pointer, and two-cycle sequences that push
// the PC on interrupt or pop it on RET/RTI while stalling upstream.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   mem_read/write    load / store at alu_data[ADDR_W-1:0]
//   push/pop          single-word stack ops on read_data2 / mem_data_out
//   ret_en            pop a 32-bit PC (two cycles)
//   interrupt_in      push pc_in, then redirect to INT_VECTOR (two cycles)
//   wb_en_in, mem_to_reg_in, write_addr_in, alu_data
//                     writeback control and data carried to the MW buffer
//   read_data2        store / push data
//   pc_in             PC travelling with the instruction
//   stall             combinational hold for EM buffer and earlier stages
//   pc_load           one-cycle PC redirect strobe, pc_target its value
//   wb_en_out, mem_to_reg_out, write_addr_out, alu_data_out, mem_data_out
//                     registered results for the MW buffer
//   sp_out            current stack pointer
//   stack_fault       sticky stack wrap flag (cleared only by reset)
module mem_stage_ctrl #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned SP_INIT    = 2**ADDR_W - 1,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              push,
  input  logic              pop,
  input  logic              ret_en,
  input  logic              interrupt_in,
  input  logic              wb_en_in,
  input  logic              mem_to_reg_in,
  input  logic [15:0]       alu_data,
  input  logic [15:0]       read_data2,
  input  logic [2:0]        write_addr_in,
  input  logic [31:0]       pc_in,
  output logic              stall,
  output logic              pc_load,
  output logic [31:0]       pc_target,
  output logic              wb_en_out,
  output logic              mem_to_reg_out,
  output logic [2:0]        write_addr_out,
  output logic [15:0]       alu_data_out,
  output logic [15:0]       mem_data_out,
  output logic [ADDR_W-1:0] sp_out,
  output logic              stack_fault
);

  typedef enum logic [1:0] {IDLE, INT_LO, RET_LO} state_t;

  state_t            state;
  logic [ADDR_W-1:0] sp;
  logic [15:0]       half_latch;
  logic [15:0]       mem [0:2**ADDR_W-1];

  logic [ADDR_W-1:0] sp_inc, sp_dec, addr;
  logic              push_wrap, pop_wrap;
  logic [15:0]       rd_sp_inc, rd_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;

  assign sp_inc    = sp + ADDR_W'(1);
  assign sp_dec    = sp - ADDR_W'(1);
  assign addr      = alu_data[ADDR_W-1:0];
  assign push_wrap = (sp == '0);
  assign pop_wrap  = (sp == '1);
  assign rd_sp_inc = mem[sp_inc];
  assign rd_addr   = mem[addr];
  assign sp_out    = sp;

  assign stall   = !reset && (state == IDLE) && (ret_en || interrupt_in);
  assign pc_load = !reset && (state != IDLE);

  // The interrupt push leaves the low half on top of the stack, so the
  // first word popped by RET is the low half and the second the high half.
  always_comb begin
    pc_target = '0;
    if (!reset) begin
      case (state)
        INT_LO:  pc_target = INT_VECTOR;
        RET_LO:  pc_target = {rd_sp_inc, half_latch};
        default: pc_target = '0;
      endcase
    end
  end

  // Single write port decode; sequence starts override plain ops.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (ret_en) begin
            mem_we = 1'b0;
          end else if (interrupt_in) begin
            mem_we    = 1'b1;
            mem_waddr = sp;
            mem_wdata = pc_in[31:16];
          end else if (push) begin
            mem_we    = 1'b1;
            mem_waddr = sp;
            mem_wdata = read_data2;
          end else if (!pop && mem_write) begin
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wdata = read_data2;
          end
        end
        INT_LO: begin
          mem_we    = 1'b1;
          mem_waddr = sp;
          mem_wdata = half_latch;
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      sp             <= ADDR_W'(SP_INIT);
      half_latch     <= '0;
      stack_fault    <= 1'b0;
      wb_en_out      <= 1'b0;
      mem_to_reg_out <= 1'b0;
      write_addr_out <= '0;
      alu_data_out   <= '0;
      mem_data_out   <= '0;
    end else begin
      // Default is a bubble; only a plain IDLE op forwards its fields.
      wb_en_out      <= 1'b0;
      mem_to_reg_out <= 1'b0;
      write_addr_out <= '0;
      alu_data_out   <= '0;
      mem_data_out   <= '0;
      case (state)
        IDLE: begin
          if (ret_en) begin
            sp          <= sp_inc;
            stack_fault <= stack_fault | pop_wrap;
            half_latch  <= rd_sp_inc;
            state       <= RET_LO;
          end else if (interrupt_in) begin
            sp          <= sp_dec;
            stack_fault <= stack_fault | push_wrap;
            half_latch  <= pc_in[15:0];
            state       <= INT_LO;
          end else begin
            wb_en_out      <= wb_en_in;
            mem_to_reg_out <= mem_to_reg_in;
            write_addr_out <= write_addr_in;
            alu_data_out   <= alu_data;
            if (push) begin
              sp          <= sp_dec;
              stack_fault <= stack_fault | push_wrap;
            end else if (pop) begin
              sp           <= sp_inc;
              stack_fault  <= stack_fault | pop_wrap;
              mem_data_out <= rd_sp_inc;
            end else if (!mem_write && mem_read) begin
              mem_data_out <= rd_addr;
            end
          end
        end
        INT_LO: begin
          sp          <= sp_dec;
          stack_fault <= stack_fault | push_wrap;
          state       <= IDLE;
        end
        RET_LO: begin
          sp          <= sp_inc;
          stack_fault <= stack_fault | pop_wrap;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  typedef struct packed {
    logic        mr, mw, pu, po, rt, it, wb, m2r;
    logic [15:0] alu, rd2;
    logic [2:0]  wa;
    logic [31:0] pc;
  } in_t;

  typedef struct packed {
    in_t         i;
    logic [15:0] md;
    logic        wb;
    logic [10:0] sp;
    logic        fault;
  } vec_t;

  logic        clk, reset;
  logic        mem_read, mem_write, push, pop, ret_en, interrupt_in;
  logic        wb_en_in, mem_to_reg_in;
  logic [15:0] alu_data, read_data2;
  logic [2:0]  write_addr_in;
  logic [31:0] pc_in;
  logic        stall, pc_load, wb_en_out, mem_to_reg_out, stack_fault;
  logic [31:0] pc_target;
  logic [2:0]  write_addr_out;
  logic [15:0] alu_data_out, mem_data_out;
  logic [10:0] sp_out;

  int total = 0;
  int bad   = 0;

  // Reference model: plain word array and a stack pointer with wrap rules.
  logic [15:0] m_mem [0:2047];
  int unsigned m_sp;
  bit          m_fault;

  mem_stage_ctrl #(.ADDR_W(11), .SP_INIT(2047), .INT_VECTOR(32'h0000_0020)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .push(push), .pop(pop), .ret_en(ret_en), .interrupt_in(interrupt_in),
    .wb_en_in(wb_en_in), .mem_to_reg_in(mem_to_reg_in), .alu_data(alu_data),
    .read_data2(read_data2), .write_addr_in(write_addr_in), .pc_in(pc_in),
    .stall(stall), .pc_load(pc_load), .pc_target(pc_target),
    .wb_en_out(wb_en_out), .mem_to_reg_out(mem_to_reg_out),
    .write_addr_out(write_addr_out), .alu_data_out(alu_data_out),
    .mem_data_out(mem_data_out), .sp_out(sp_out), .stack_fault(stack_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t op(input bit mr, mw, pu, po, input logic [15:0] alu, rd2,
                             input bit wb, m2r, input logic [2:0] wa);
    in_t x;
    x = '0;
    x.mr = mr; x.mw = mw; x.pu = pu; x.po = po;
    x.alu = alu; x.rd2 = rd2; x.wb = wb; x.m2r = m2r; x.wa = wa;
    return x;
  endfunction

  function automatic vec_t mkv(input in_t x, input logic [15:0] md, input logic wb,
                               input logic [10:0] sp, input logic fault);
    vec_t v;
    v.i = x; v.md = md; v.wb = wb; v.sp = sp; v.fault = fault;
    return v;
  endfunction

  task automatic drive(input in_t x);
    mem_read = x.mr; mem_write = x.mw; push = x.pu; pop = x.po;
    ret_en = x.rt; interrupt_in = x.it; wb_en_in = x.wb; mem_to_reg_in = x.m2r;
    alu_data = x.alu; read_data2 = x.rd2; write_addr_in = x.wa; pc_in = x.pc;
  endtask

  // All stimulus tasks start and end at posedge + 1.
  task automatic apply_vec(input vec_t v);
    drive(v.i);
    @(negedge clk);
    chk("vec_stall", stall, 0);
    chk("vec_pc_load", pc_load, 0);
    @(posedge clk); #1;
    chk("vec_mem_data", mem_data_out, v.md);
    chk("vec_wb_en", wb_en_out, v.wb);
    chk("vec_m2r", mem_to_reg_out, v.i.m2r);
    chk("vec_waddr", write_addr_out, v.i.wa);
    chk("vec_alu", alu_data_out, v.i.alu);
    chk("vec_sp", sp_out, v.sp);
    chk("vec_fault", stack_fault, v.fault);
  endtask

  task automatic do_reset();
    drive('0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic void m_push(input logic [15:0] d);
    m_mem[m_sp] = d;
    if (m_sp == 0) begin m_fault = 1'b1; m_sp = 2047; end
    else m_sp = m_sp - 1;
  endfunction

  function automatic logic [15:0] m_pop();
    if (m_sp == 2047) begin m_fault = 1'b1; m_sp = 0; end
    else m_sp = m_sp + 1;
    return m_mem[m_sp];
  endfunction

  task automatic run_op(input in_t x);
    logic [15:0] lo, hi, md;
    logic [31:0] tgt;
    drive(x);
    if (x.rt || x.it) begin
      @(negedge clk);
      chk("seq_stall1", stall, 1);
      chk("seq_pc_load1", pc_load, 0);
      lo = '0;
      if (x.rt) lo = m_pop();
      else m_push(x.pc[31:16]);
      @(posedge clk); #1;
      chk("seq_wb1", wb_en_out, 0);
      chk("seq_m2r1", mem_to_reg_out, 0);
      chk("seq_sp1", sp_out, 32'(m_sp));
      if (x.rt) begin hi = m_pop(); tgt = {hi, lo}; end
      else begin m_push(x.pc[15:0]); tgt = 32'h0000_0020; end
      @(negedge clk);
      chk("seq_stall2", stall, 0);
      chk("seq_pc_load2", pc_load, 1);
      chk("seq_target", pc_target, tgt);
      @(posedge clk); #1;
      chk("seq_wb2", wb_en_out, 0);
      chk("seq_m2r2", mem_to_reg_out, 0);
      chk("seq_sp2", sp_out, 32'(m_sp));
      chk("seq_fault", stack_fault, 32'(m_fault));
    end else begin
      md = '0;
      if (x.pu) m_push(x.rd2);
      else if (x.po) md = m_pop();
      else if (x.mw) m_mem[x.alu[10:0]] = x.rd2;
      else if (x.mr) md = m_mem[x.alu[10:0]];
      @(negedge clk);
      chk("rnd_stall", stall, 0);
      chk("rnd_pc_load", pc_load, 0);
      @(posedge clk); #1;
      chk("rnd_mem_data", mem_data_out, md);
      chk("rnd_wb", wb_en_out, x.wb);
      chk("rnd_m2r", mem_to_reg_out, x.m2r);
      chk("rnd_waddr", write_addr_out, x.wa);
      chk("rnd_alu", alu_data_out, x.alu);
      chk("rnd_sp", sp_out, 32'(m_sp));
      chk("rnd_fault", stack_fault, 32'(m_fault));
    end
  endtask

  vec_t tbl [13];
  in_t  x;

  initial begin
    drive('0);
    reset = 1'b1;
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_target", pc_target, 0);
    chk("rst_wb", wb_en_out, 0);
    chk("rst_m2r", mem_to_reg_out, 0);
    chk("rst_waddr", write_addr_out, 0);
    chk("rst_alu", alu_data_out, 0);
    chk("rst_md", mem_data_out, 0);
    chk("rst_sp", sp_out, 11'h7FF);
    chk("rst_fault", stack_fault, 0);
    do_reset();

    //               mr mw pu po  alu        rd2        wb m2r wa     md        wb  sp      f
    tbl[0]  = mkv(op(0, 1, 0, 0, 16'h0010, 16'hBEEF, 0, 0, 3'd0), 16'h0000, 0, 11'h7FF, 0);
    tbl[1]  = mkv(op(1, 0, 0, 0, 16'h0010, 16'h0000, 1, 1, 3'd5), 16'hBEEF, 1, 11'h7FF, 0);
    tbl[2]  = mkv(op(0, 0, 1, 0, 16'h0000, 16'h1234, 0, 0, 3'd0), 16'h0000, 0, 11'h7FE, 0);
    tbl[3]  = mkv(op(0, 0, 0, 1, 16'h0000, 16'h0000, 1, 1, 3'd2), 16'h1234, 1, 11'h7FF, 0);
    tbl[4]  = mkv(op(0, 1, 0, 0, 16'h0020, 16'h1111, 0, 0, 3'd0), 16'h0000, 0, 11'h7FF, 0);
    tbl[5]  = mkv(op(1, 1, 1, 1, 16'h0020, 16'h5555, 1, 0, 3'd3), 16'h0000, 1, 11'h7FE, 0);
    tbl[6]  = mkv(op(1, 1, 0, 1, 16'h0020, 16'h6666, 0, 1, 3'd4), 16'h5555, 0, 11'h7FF, 0);
    tbl[7]  = mkv(op(1, 0, 0, 0, 16'h0020, 16'h0000, 1, 1, 3'd1), 16'h1111, 1, 11'h7FF, 0);
    tbl[8]  = mkv(op(1, 1, 0, 0, 16'h0030, 16'hABCD, 0, 0, 3'd0), 16'h0000, 0, 11'h7FF, 0);
    tbl[9]  = mkv(op(1, 0, 0, 0, 16'h0030, 16'h0000, 1, 1, 3'd6), 16'hABCD, 1, 11'h7FF, 0);
    tbl[10] = mkv(op(0, 1, 0, 0, 16'hF810, 16'h7777, 0, 0, 3'd0), 16'h0000, 0, 11'h7FF, 0);
    tbl[11] = mkv(op(1, 0, 0, 0, 16'h0010, 16'h0000, 1, 1, 3'd7), 16'h7777, 1, 11'h7FF, 0);
    tbl[12] = mkv(op(1, 0, 0, 0, 16'hF810, 16'h0000, 1, 0, 3'd1), 16'h7777, 1, 11'h7FF, 0);
    for (int i = 0; i < 13; i++) apply_vec(tbl[i]);

    // Interrupt push, then immediate return; writeback enable held high.
    x = op(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 3'd2);
    x.it = 1'b1; x.pc = 32'h0001_00A4;
    drive(x);
    @(negedge clk);
    chk("int_stall1", stall, 1);
    chk("int_pc_load1", pc_load, 0);
    @(posedge clk); #1;
    chk("int_wb1", wb_en_out, 0);
    chk("int_sp1", sp_out, 11'h7FE);
    @(negedge clk);
    chk("int_stall2", stall, 0);
    chk("int_pc_load2", pc_load, 1);
    chk("int_target", pc_target, 32'h0000_0020);
    @(posedge clk); #1;
    chk("int_wb2", wb_en_out, 0);
    chk("int_sp2", sp_out, 11'h7FD);
    x.it = 1'b0; x.rt = 1'b1; x.pc = 32'h0;
    drive(x);
    @(negedge clk);
    chk("ret_stall1", stall, 1);
    chk("ret_pc_load1", pc_load, 0);
    @(posedge clk); #1;
    chk("ret_wb1", wb_en_out, 0);
    chk("ret_sp1", sp_out, 11'h7FE);
    @(negedge clk);
    chk("ret_stall2", stall, 0);
    chk("ret_pc_load2", pc_load, 1);
    chk("ret_target", pc_target, 32'h0001_00A4);
    @(posedge clk); #1;
    chk("ret_wb2", wb_en_out, 0);
    chk("ret_sp2", sp_out, 11'h7FF);
    apply_vec(mkv(op(1, 0, 0, 0, 16'h07FF, 16'h0, 1, 1, 3'd1), 16'h0001, 1, 11'h7FF, 0));
    apply_vec(mkv(op(1, 0, 0, 0, 16'h07FE, 16'h0, 1, 1, 3'd1), 16'h00A4, 1, 11'h7FF, 0));

    // Pop wrap at SP max; memory survives reset; fault stays sticky.
    apply_vec(mkv(op(0, 1, 0, 0, 16'h0000, 16'h0BAD, 0, 0, 3'd0), 16'h0000, 0, 11'h7FF, 0));
    do_reset();
    apply_vec(mkv(op(0, 0, 0, 1, 16'h0000, 16'h0000, 1, 1, 3'd2), 16'h0BAD, 1, 11'h000, 1));
    apply_vec(mkv(op(0, 1, 0, 0, 16'h0040, 16'h4444, 0, 0, 3'd0), 16'h0000, 0, 11'h000, 1));
    apply_vec(mkv(op(1, 0, 0, 0, 16'h0040, 16'h0000, 1, 1, 3'd3), 16'h4444, 1, 11'h000, 1));
    apply_vec(mkv(op(0, 0, 1, 0, 16'h0000, 16'h9999, 0, 0, 3'd0), 16'h0000, 0, 11'h7FF, 1));

    // Reset in the second cycle of an interrupt sequence.
    do_reset();
    x = '0; x.it = 1'b1; x.pc = 32'hCAFE_1234;
    drive(x);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_stall", stall, 0);
    chk("mid_pc_load", pc_load, 0);
    chk("mid_target", pc_target, 0);
    chk("mid_sp", sp_out, 11'h7FF);
    chk("mid_wb", wb_en_out, 0);
    drive('0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_pc_load_after", pc_load, 0);
    apply_vec(mkv(op(1, 0, 0, 0, 16'h07FF, 16'h0, 1, 1, 3'd4), 16'hCAFE, 1, 11'h7FF, 0));

    // Fill every word via pushes; the last push wraps at SP=0.
    do_reset();
    m_sp = 2047;
    m_fault = 1'b0;
    for (int i = 0; i < 2048; i++)
      run_op(op(0, 0, 1, 0, 16'h0, 16'((i * 40503) ^ 23130), 0, 0, 3'd0));
    do_reset();
    m_sp = 2047;
    m_fault = 1'b0;
    chk("fill_rst_fault", stack_fault, 0);

    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      x.mr = 1'($urandom); x.mw = 1'($urandom);
      x.pu = ($urandom_range(0, 3) == 0);
      x.po = ($urandom_range(0, 3) == 0);
      x.rt = (r < 8);
      x.it = (r >= 5 && r < 15);
      x.wb = 1'($urandom); x.m2r = 1'($urandom);
      x.alu = 16'($urandom); x.rd2 = 16'($urandom);
      x.wa = 3'($urandom); x.pc = $urandom;
      run_op(x);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
